bg_flash_fetch: RTL and testbench

//  Upstream stage of the background pixel path. It accepts packed 4bpp pixel

---
 rtl/bg_fetch_pkg.sv | 26 ++
 rtl/bg_flash_fetch.sv | 152 +++++++++++++++
 tb/tb_bg_flash_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bg_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bg_fetch_pkg : shared types and nibble helper for the background pixel fetch
// Revision     : 1.0
// ---------------------------------------------------------------------------
package bg_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    OUT    = 2'd2
  } fetch_state_t;

  localparam int PIX_PER_BYTE    = 2;
  localparam bit HI_NIBBLE_FIRST = 1'b1;
  localparam int NIB_IDX_W       = $clog2(PIX_PER_BYTE);

  function automatic logic [3:0] sel_nibble(input logic [7:0] b,
                                            input logic [NIB_IDX_W-1:0] nib);
    logic take_hi;
    take_hi = (nib == '0) ? HI_NIBBLE_FIRST : !HI_NIBBLE_FIRST;
    return take_hi ? b[7:4] : b[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bg_flash_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bg_flash_fetch : 4bpp pixel fetch from parallel flash with a 1-byte cache
// Revision       : 1.0
// ---------------------------------------------------------------------------
module bg_flash_fetch
  import bg_fetch_pkg::*;
#(
  parameter int FL_AW       = 23,
  parameter int WAIT_CYCLES = 5,
  parameter int PIX_W       = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FL_AW:0]   req_pix_addr,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [FL_AW-1:0] fl_addr,
  output logic             fl_oe_n,
  input  logic [7:0]       fl_dq,
  input  logic             fl_ry
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  fetch_state_t         state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]     pix_data_q, pix_data_d;
  logic [FL_AW-1:0]     fl_addr_q, fl_addr_d;
  logic                 fl_oe_n_q, fl_oe_n_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NIB_IDX_W-1:0] nib_q, nib_d;
  logic [7:0]           cache_data_q, cache_data_d;
  logic [FL_AW-1:0]     cache_tag_q, cache_tag_d;
  logic                 cache_valid_q, cache_valid_d;

  logic                 accept;
  logic [FL_AW-1:0]     req_byte;
  logic                 hit;

  assign accept   = req_valid & req_ready_q;
  assign req_byte = req_pix_addr[FL_AW:1];
  // A flush in the accept cycle forces a miss even if the tag matches.
  assign hit      = cache_valid_q & (cache_tag_q == req_byte) & ~flush;

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    pix_valid_d   = pix_valid_q;
    pix_data_d    = pix_data_q;
    fl_addr_d     = fl_addr_q;
    fl_oe_n_d     = fl_oe_n_q;
    cnt_d         = cnt_q;
    nib_d         = nib_q;
    cache_data_d  = cache_data_q;
    cache_tag_d   = cache_tag_q;
    cache_valid_d = cache_valid_q & ~flush;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          nib_d       = req_pix_addr[NIB_IDX_W-1:0];
          if (hit) begin
            pix_data_d  = PIX_W'(sel_nibble(cache_data_q, req_pix_addr[NIB_IDX_W-1:0]));
            pix_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            fl_addr_d = req_byte;
            cnt_d     = CNT_W'(WAIT_CYCLES - 1);
            fl_oe_n_d = 1'b0;
            state_d   = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (fl_ry) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // The captured nibble is delivered even if flush drops the cache line.
            cache_data_d  = fl_dq;
            cache_tag_d   = fl_addr_q;
            cache_valid_d = ~flush;
            pix_data_d    = PIX_W'(sel_nibble(fl_dq, nib_q));
            pix_valid_d   = 1'b1;
            fl_oe_n_d     = 1'b1;
            state_d       = OUT;
          end
        end
      end

      OUT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        pix_valid_d = 1'b0;
        fl_oe_n_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      fl_addr_q     <= '0;
      fl_oe_n_q     <= 1'b1;
      cnt_q         <= '0;
      nib_q         <= '0;
      cache_data_q  <= '0;
      cache_tag_q   <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      fl_addr_q     <= fl_addr_d;
      fl_oe_n_q     <= fl_oe_n_d;
      cnt_q         <= cnt_d;
      nib_q         <= nib_d;
      cache_data_q  <= cache_data_d;
      cache_tag_q   <= cache_tag_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign fl_addr   = fl_addr_q;
  assign fl_oe_n   = fl_oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_flash_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bg_flash_fetch : scoreboard bench for bg_flash_fetch
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_bg_flash_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_pix_addr = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [3:0]  pix_data;
  logic [22:0] fl_addr;
  logic        fl_oe_n;
  logic [7:0]  fl_dq;
  logic        fl_ry = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [3:0] sb[$];

  always #10 Clk = ~Clk;

  // Flash contents: bytes 0 and 1 fixed, everything else a hash of the address.
  function automatic logic [7:0] fl_model(input logic [22:0] a);
    if (a == 23'd0) return 8'hA5;
    if (a == 23'd1) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  assign fl_dq = fl_model(fl_addr);

  bg_flash_fetch #(.FL_AW(23), .WAIT_CYCLES(5), .PIX_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pix_addr(req_pix_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .fl_addr(fl_addr), .fl_oe_n(fl_oe_n), .fl_dq(fl_dq), .fl_ry(fl_ry)
  );

  task automatic do_req(input logic [23:0] addr, input int exp_lat,
                        input logic [3:0] exp_data, input int exp_oe,
                        input logic flush_at_accept, input int ry_start,
                        input int ry_len, input int flush_at, input int hold,
                        input string name);
    int lat, oe, guard;
    logic [3:0] exp, held;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout got=%b want=1", name, req_ready);
    end
    req_valid    = 1'b1;
    req_pix_addr = addr;
    flush        = flush_at_accept;
    sb.push_back(exp_data);
    @(posedge Clk);
    #1;
    req_valid    = 1'b0;
    flush        = 1'b0;
    req_pix_addr = 24'($urandom);
    lat = 1;
    oe  = 0;
    if (exp_oe > 0) begin
      checks++;
      if (fl_addr !== addr[23:1]) begin
        failures++;
        $display("FAIL %s fl_addr got=%h want=%h", name, fl_addr, addr[23:1]);
      end
    end
    guard = 0;
    while (pix_valid !== 1'b1 && guard < 60) begin
      if (fl_oe_n === 1'b0) oe++;
      fl_ry = !(lat >= ry_start && lat < ry_start + ry_len);
      flush = (lat == flush_at);
      @(posedge Clk);
      #1;
      lat++;
      guard++;
    end
    fl_ry = 1'b1;
    flush = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (oe != exp_oe) begin
      failures++;
      $display("FAIL %s oe_cycles got=%0d want=%0d", name, oe, exp_oe);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    checks++;
    if (pix_data !== exp) begin
      failures++;
      $display("FAIL %s pix_data got=%h want=%h", name, pix_data, exp);
    end
    held = pix_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== held || req_ready !== 1'b0 || fl_oe_n !== 1'b1) begin
        failures++;
        $display("FAIL %s hold%0d got v=%b d=%h rdy=%b oe_n=%b want v=1 d=%h rdy=0 oe_n=1",
                 name, i, pix_valid, pix_data, req_ready, fl_oe_n, held);
      end
    end
    pix_ready = 1'b1;
    @(posedge Clk);
    #1;
    pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got v=%b rdy=%b want v=0 rdy=1", name, pix_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 4'h0 ||
        fl_addr !== 23'h0 || fl_oe_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h a=%h oe_n=%b want 0 0 0 0 1",
               req_ready, pix_valid, pix_data, fl_addr, fl_oe_n);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise got=%b want=1", req_ready);
    end
  endtask

  task automatic test_miss_hit;
    do_req(24'h000000, 6, 4'hA, 5, 1'b0, 0, 0, 0, 0, "miss0");
    do_req(24'h000001, 1, 4'h5, 0, 1'b0, 0, 0, 0, 0, "hit1");
  endtask

  task automatic test_ry_stall;
    do_req(24'h000002, 9, 4'h3, 8, 1'b0, 2, 3, 0, 0, "ry_stall");
  endtask

  task automatic test_backpressure;
    do_req(24'h000003, 1, 4'hC, 0, 1'b0, 0, 0, 0, 10, "backpressure");
  endtask

  task automatic test_flush;
    do_req(24'h000003, 6, 4'hC, 5, 1'b1, 0, 0, 0, 0, "flush_accept");
    do_req(24'h000004, 6, 4'h5, 5, 1'b0, 0, 0, 5, 0, "flush_capture");
    do_req(24'h000005, 6, 4'h8, 5, 1'b0, 0, 0, 0, 0, "after_flush");
  endtask

  task automatic test_top_addr;
    do_req(24'hFFFFFF, 6, 4'h5, 5, 1'b0, 0, 0, 0, 0, "top_miss");
    do_req(24'hFFFFFE, 1, 4'h2, 0, 1'b0, 0, 0, 0, 0, "top_hit");
  endtask

  task automatic test_reset_in_access;
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    req_valid    = 1'b1;
    req_pix_addr = 24'h000004;
    sb.push_back(4'h5);
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (fl_oe_n !== 1'b0) begin
      failures++;
      $display("FAIL rst_access_pre oe_n got=%b want=0", fl_oe_n);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (fl_oe_n !== 1'b1 || pix_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_access got oe_n=%b v=%b rdy=%b want 1 0 0", fl_oe_n, pix_valid, req_ready);
    end
    void'(sb.pop_front());
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got rdy=%b v=%b want 1 0", req_ready, pix_valid);
    end
    do_req(24'h000001, 6, 4'h5, 5, 1'b0, 0, 0, 0, 0, "post_reset_miss");
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_ry_stall();
    test_backpressure();
    test_flush();
    test_top_addr();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
